inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction register. It holds the program counter and issues word reads to the instruction ROM over a req/ack handshake. It presents each fetched word on Inst with a one-cycle Write_IR strobe, and redirects the PC on branches. Condition-code gating is not done here; it is done by the downstream instruction register.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] forced to 0)
ROM_IDX_W, 6, ROM word-address width; ROM depth = 2**ROM_IDX_W words
NOP_WORD, 32'hE1A00000, word substituted on fetch error (MOV r0,r0)

Ports:
clk  in  1  clock; all state updates on posedge
Rst  in  1  synchronous, active-high reset
fetch_en  in  1  control unit requests next instruction
stall  in  1  downstream not ready; hold presented instruction
branch_valid  in  1  one-cycle redirect request
branch_target  in  32  redirect address
rom_req  out  1  ROM read request
rom_addr  out  ROM_IDX_W  ROM word address = PC[ROM_IDX_W+1:2]
rom_ack  in  1  ROM data valid this cycle
rom_data  in  32  ROM read data
Inst  out  32  fetched instruction, to instruction register
Write_IR  out  1  Inst valid; instruction register captures it
PC  out  32  address of instruction being fetched or presented
PC_plus4  out  32  PC + 4, modulo 2**32
fetch_busy  out  1  high in REQ or HOLD
fetch_err  out  1  present only with FETCH_ERR_EN

Behaviour:
- Reset (Rst=1 at posedge, any state, including mid-request):
  - state=IDLE, PC=RESET_PC&~3, Inst=0, Write_IR=0, rom_req=0, discard=0, fetch_err=0.
  - An outstanding ROM ack after reset is ignored, because rom_req=0 and the FSM is in IDLE.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - fetch_en=1 -> REQ; rom_req rises next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - rom_req=1 and rom_addr stable until the cycle in which rom_ack=1.
  - On ack: Inst<=rom_data, Write_IR<=1 next cycle, state -> HOLD.
  - Minimum latency from fetch_en to Write_IR is 2 cycles when ack is combinational in the first REQ cycle.
- HOLD:
  - Write_IR=1 and Inst held.
  - A transfer completes on any cycle with Write_IR=1 and stall=0. On that cycle:
    - PC<=PC+4, with wrap 0xFFFFFFFC -> 0x00000000.
    - Write_IR<=0.
    - Next state is REQ if fetch_en=1, otherwise IDLE.
  - stall=1: Write_IR, Inst and PC all held, for any number of cycles.
- Branch (branch_valid=1), in any state:
  - PC<=branch_target&~3 next cycle. The incremented PC is not applied.
  - In REQ with no ack this cycle: set discard. The next ack's data is dropped (no Write_IR), discard clears, and the FSM re-requests at the new PC in the following cycle.
  - In REQ with ack in the same cycle: data dropped; stay in REQ and request the new PC.
  - In HOLD: Write_IR<=0 and the presented instruction is dropped, even if stall=1. Next state is REQ if fetch_en=1, otherwise IDLE.
  - In IDLE: only the PC is loaded.
  - branch_valid has priority over stall and over transfer completion.
- rom_ack outside REQ is ignored.
- PC_plus4 is combinational from PC.
- fetch_busy = (state != IDLE).

Optional Feature:
FETCH_ERR_EN
- Defined:
  - In REQ, if PC[31:ROM_IDX_W+2] != 0, no rom_req is issued.
  - The next cycle behaves as an ack with data NOP_WORD: HOLD, Write_IR=1.
  - fetch_err is set and is sticky until Rst.
  - Branch and discard rules apply unchanged.
- Undefined:
  - Upper PC bits are ignored; rom_addr wraps within the ROM.
  - The fetch_err port is absent.

Test Plan:
- Reset, then fetch_en=1 with ROM ack 1 cycle after req: rom_addr=0, then Inst=ROM[0] with Write_IR high 1 cycle; second fetch uses rom_addr=1 and PC=0x4.
- stall=1 for 3 cycles during HOLD: Inst, PC and Write_IR held for 3 cycles; PC becomes 0x4 only after stall drops.
- branch_valid with branch_target=0x23 while in REQ, ack delayed 2 cycles: the stale word is dropped with no Write_IR; the next request has rom_addr=8 and PC=0x20.
- branch_valid and rom_ack in the same cycle: no Write_IR for that word; the next request targets the branch address.
- Rst asserted mid-REQ while ack is pending: outputs go to reset values next cycle; the late ack causes no Write_IR; PC=RESET_PC.
- FETCH_ERR_EN defined, branch to 0x100 with ROM_IDX_W=6: no rom_req is issued, Inst=0xE1A00000, fetch_err=1 and stays set after later good fetches.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction ROM read port: level req held until a one-cycle ack returns the word.
interface inst_fetch_if #(parameter int ROM_IDX_W = 6);
    logic                 rom_req;
    logic [ROM_IDX_W-1:0] rom_addr;
    logic                 rom_ack;
    logic [31:0]          rom_data;

    modport master (output rom_req, rom_addr, input rom_ack, rom_data);
    modport slave  (input rom_req, rom_addr, output rom_ack, rom_data);
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, ROM req/ack, one-word presentation to the instruction register.
// Optional FETCH_ERR_EN: out-of-ROM PCs fetch NOP_WORD and raise sticky fetch_err.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_IDX_W = 6,
    parameter logic [31:0] NOP_WORD  = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    inst_fetch_if.master rom,
    output logic [31:0] Inst,
    output logic        Write_IR,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        fetch_busy
`ifdef FETCH_ERR_EN
    ,
    output logic        fetch_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_nxt;
    logic        discard, discard_nxt;
    logic [31:0] pc_nxt;
    logic        load_inst;
    logic        pc_err;
    logic        take;
    logic [31:0] take_data;

`ifdef FETCH_ERR_EN
    assign pc_err = (state == REQ) && (PC[31:ROM_IDX_W+2] != '0);
`else
    assign pc_err = 1'b0;
`endif

    // An out-of-range PC completes immediately as if the ROM had returned a NOP.
    assign take      = (state == REQ) && (pc_err || rom.rom_ack);
    assign take_data = pc_err ? NOP_WORD : rom.rom_data;

    assign rom.rom_req  = (state == REQ) && !pc_err;
    assign rom.rom_addr = PC[ROM_IDX_W+1:2];
    assign Write_IR     = (state == HOLD);
    assign fetch_busy   = (state != IDLE);
    assign PC_plus4     = PC + 32'd4;

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        pc_nxt      = PC;
        load_inst   = 1'b0;
        if (branch_valid)
            pc_nxt = branch_target & ~32'h3;
        case (state)
            IDLE: if (fetch_en) state_nxt = REQ;
            REQ: begin
                if (take) begin
                    // Word belongs to the pre-branch PC: drop it and re-request.
                    if (branch_valid || discard) begin
                        discard_nxt = 1'b0;
                    end else begin
                        load_inst = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (branch_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (branch_valid || !stall) begin
                    state_nxt = fetch_en ? REQ : IDLE;
                    if (!branch_valid)
                        pc_nxt = PC_plus4;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            PC      <= RESET_PC & ~32'h3;
            Inst    <= '0;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            PC      <= pc_nxt;
            discard <= discard_nxt;
            if (load_inst)
                Inst <= take_data;
        end
    end

`ifdef FETCH_ERR_EN
    always_ff @(posedge clk) begin
        if (Rst)
            fetch_err <= 1'b0;
        else if (pc_err)
            fetch_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; transaction-level model checked every cycle.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] Inst, PC, PC_plus4;
    logic        Write_IR, fetch_busy;
`ifdef FETCH_ERR_EN
    logic        fetch_err;
`endif

    inst_fetch_if #(.ROM_IDX_W(6)) rif();

    inst_fetch_unit #(.RESET_PC(32'h0), .ROM_IDX_W(6), .NOP_WORD(32'hE1A00000)) dut (
        .clk(clk), .Rst(Rst), .fetch_en(fetch_en), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .rom(rif), .Inst(Inst), .Write_IR(Write_IR), .PC(PC),
        .PC_plus4(PC_plus4), .fetch_busy(fetch_busy)
`ifdef FETCH_ERR_EN
        , .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] rom [64];
    int tests = 0;
    int fails = 0;

    // Model: a request is outstanding, a word is being presented, or neither.
    logic [31:0] m_pc = 32'h0, m_inst = 32'h0;
    bit m_wait = 0, m_pres = 0, m_drop = 0, m_err = 0;

    function automatic bit m_bad();
`ifdef FETCH_ERR_EN
        return m_wait && (m_pc[31:8] != 24'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clk();
        logic [31:0] old_pc, d;
        bit bad, took;
        if (Rst) begin
            m_pc = 32'h0; m_inst = 32'h0;
            m_wait = 0; m_pres = 0; m_drop = 0; m_err = 0;
        end else begin
            old_pc = m_pc;
            bad  = m_bad();
            took = m_wait && (bad || rif.rom_ack);
            d    = bad ? 32'hE1A00000 : rom[old_pc[7:2]];
            if (bad) m_err = 1;
            if (branch_valid) m_pc = branch_target & ~32'h3;
            if (m_wait) begin
                if (took) begin
                    if (branch_valid || m_drop) m_drop = 0;
                    else begin m_inst = d; m_wait = 0; m_pres = 1; end
                end else if (branch_valid) m_drop = 1;
            end else if (m_pres) begin
                if (branch_valid || !stall) begin
                    m_pres = 0;
                    m_wait = fetch_en;
                    if (!branch_valid) m_pc = old_pc + 32'd4;
                end
            end else begin
                m_wait = fetch_en;
            end
        end
    endtask

    task automatic compare();
        chk("rom_req", 32'(rif.rom_req), 32'(m_wait && !m_bad()));
        if (m_wait) chk("rom_addr", 32'(rif.rom_addr), 32'(m_pc[7:2]));
        chk("Write_IR", 32'(Write_IR), 32'(m_pres));
        chk("Inst", Inst, m_inst);
        chk("PC", PC, m_pc);
        chk("PC_plus4", PC_plus4, m_pc + 32'd4);
        chk("fetch_busy", 32'(fetch_busy), 32'(m_wait || m_pres));
`ifdef FETCH_ERR_EN
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
`endif
    endtask

    // One clock: drive inputs, let the bench ROM answer, advance model, compare.
    task automatic cyc(input bit rst, input bit fe, input bit st, input bit bv,
                       input logic [31:0] bt, input bit ack);
        Rst = rst; fetch_en = fe; stall = st; branch_valid = bv; branch_target = bt;
        rif.rom_ack  = ack;
        rif.rom_data = rom[rif.rom_addr];
        @(posedge clk);
        model_clk();
        @(negedge clk);
        compare();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA0000000 + 32'(i);
        rif.rom_ack = 1'b0;
        rif.rom_data = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lit_rst_pc", PC, 32'h0);
        chk("lit_rst_inst", Inst, 32'h0);
        chk("lit_rst_wir", 32'(Write_IR), 32'h0);
        chk("lit_rst_req", 32'(rif.rom_req), 32'h0);

        // Basic fetch, ack one cycle after req rises
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit_req_addr0", 32'(rif.rom_addr), 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("lit_inst0", Inst, 32'hA0000000);
        chk("lit_wir0", 32'(Write_IR), 32'h1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit_pc4", PC, 32'h4);
        chk("lit_addr1", 32'(rif.rom_addr), 32'h1);

        // Stall for three cycles while presenting
        cyc(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("lit_stall_pc", PC, 32'h4);
            chk("lit_stall_inst", Inst, 32'hA0000001);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_after_stall_pc", PC, 32'h8);

        // Branch during REQ, stale ack arrives later
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h23, 0);
        chk("lit_br_pc", PC, 32'h20);
        chk("lit_br_addr", 32'(rif.rom_addr), 32'h8);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("lit_stale_drop", 32'(Write_IR), 32'h0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("lit_br_inst", Inst, 32'hA0000008);
        cyc(0, 0, 0, 0, 0, 0);

        // Branch and ack in the same cycle
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h40, 1);
        chk("lit_same_drop", 32'(Write_IR), 32'h0);
        chk("lit_same_addr", 32'(rif.rom_addr), 32'h10);
        cyc(0, 1, 0, 0, 0, 1);
        chk("lit_same_inst", Inst, 32'hA0000010);

        // Branch while stalled in HOLD drops the word
        cyc(0, 0, 1, 1, 32'h10, 0);
        chk("lit_hold_br_wir", 32'(Write_IR), 32'h0);
        chk("lit_hold_br_pc", PC, 32'h10);

        // PC wrap at the top of the address space
        cyc(0, 0, 0, 1, 32'hFFFFFFFE, 0);
        chk("lit_top_pc", PC, 32'hFFFFFFFC);
        chk("lit_top_plus4", PC_plus4, 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
`ifndef FETCH_ERR_EN
        chk("lit_top_inst", Inst, 32'hA000003F);
`endif
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_wrap_pc", PC, 32'h0);

        // Reset in the middle of a request; late ack must be ignored
        cyc(0, 0, 0, 1, 32'h30, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lit_mid_rst_req", 32'(rif.rom_req), 32'h0);
        chk("lit_mid_rst_pc", PC, 32'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("lit_late_ack", 32'(Write_IR), 32'h0);

`ifdef FETCH_ERR_EN
        cyc(0, 0, 0, 1, 32'h100, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit_err_noreq", 32'(rif.rom_req), 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit_err_inst", Inst, 32'hE1A00000);
        chk("lit_err_flag", 32'(fetch_err), 32'h1);
        cyc(0, 1, 0, 1, 32'h0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("lit_err_good", Inst, 32'hA0000000);
        chk("lit_err_sticky", 32'(fetch_err), 32'h1);
`endif

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
